// File: rtl/enc_bpsk_if.sv
// enc_bpsk_if: byte handshake between a byte source and the BPSK encoder.
//   data_in    : byte to transmit, sampled when data_valid & ready
//   data_valid : source has a byte
//   ready      : encoder can accept a byte (only while idle)
// master = byte source, slave = encoder.
interface enc_bpsk_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;

    modport master (output data_in, output data_valid, input ready);
    modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/enc_bpsk.sv
// enc_bpsk: frames one byte and spreads it with a 31-chip m-sequence.
// A frame is the 31-chip sync word (MSB first) followed by 8 data bits,
// MSB first; each data bit spans one full m-sequence period and a 1 bit
// inverts the sequence. Every chip is held for CHIP_DIV clocks.
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   bus        : byte handshake (data_in, data_valid, ready)
//   signal     : registered chip output
//   chip_stb   : one-clock pulse on the first clock of each chip
//   busy       : frame in progress
//   frame_done : one-clock pulse on the last clock of the last chip
module enc_bpsk #(
    parameter logic [4:0]  FASE_PARAM = 5'b10101,
    parameter logic [4:0]  TYPE_PARAM = 5'b11101,
    parameter logic [30:0] SYNC_WORD  = 31'b0011001100111100110000000011110,
    parameter int unsigned CHIP_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    enc_bpsk_if.slave  bus,
    output logic       signal,
    output logic       chip_stb,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] DIV_LAST = 8'(CHIP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] div_cnt, div_n;
    logic [4:0] chip_cnt, chip_n;
    logic [2:0] bit_cnt, bit_n;
    logic [4:0] lfsr, lfsr_n;
    logic [7:0] shreg, shreg_n;
    logic       signal_n, stb_n, done_n;
    logic       last_div, last_chip, fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            chip_cnt   <= '0;
            bit_cnt    <= '0;
            lfsr       <= FASE_PARAM;
            shreg      <= '0;
            signal     <= 1'b0;
            chip_stb   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bus.ready  <= 1'b1;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            chip_cnt   <= chip_n;
            bit_cnt    <= bit_n;
            lfsr       <= lfsr_n;
            shreg      <= shreg_n;
            signal     <= signal_n;
            chip_stb   <= stb_n;
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
            bus.ready  <= (state_n == IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        chip_n    = chip_cnt;
        bit_n     = bit_cnt;
        lfsr_n    = lfsr;
        shreg_n   = shreg;
        last_div  = (div_cnt == DIV_LAST);
        last_chip = (chip_cnt == 5'd30);
        fb        = ^(lfsr & TYPE_PARAM);

        case (state)
            IDLE: begin
                if (bus.data_valid && bus.ready) begin
                    state_n = SYNC;
                    div_n   = '0;
                    chip_n  = '0;
                    shreg_n = bus.data_in;
                end
            end
            SYNC: begin
                if (last_div) begin
                    div_n = '0;
                    if (last_chip) begin
                        state_n = DATA;
                        chip_n  = '0;
                        bit_n   = 3'd7;
                        lfsr_n  = FASE_PARAM;
                    end else begin
                        chip_n = chip_cnt + 5'd1;
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            DATA: begin
                if (last_div) begin
                    div_n = '0;
                    if (last_chip) begin
                        // Every data bit restarts the sequence from the seed.
                        chip_n = '0;
                        lfsr_n = FASE_PARAM;
                        if (bit_cnt == 3'd0) begin
                            state_n = IDLE;
                        end else begin
                            bit_n   = bit_cnt - 3'd1;
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    end else begin
                        chip_n = chip_cnt + 5'd1;
                        lfsr_n = {fb, lfsr[4:1]};
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state
        // values; this puts the first sync chip on the clock after accept.
        signal_n = 1'b0;
        stb_n    = 1'b0;
        done_n   = 1'b0;
        case (state_n)
            SYNC: begin
                signal_n = SYNC_WORD[5'd30 - chip_n];
                stb_n    = (div_n == 8'd0);
            end
            DATA: begin
                signal_n = lfsr_n[0] ^ shreg_n[7];
                stb_n    = (div_n == 8'd0);
                done_n   = (bit_n == 3'd0) && (chip_n == 5'd30) && (div_n == DIV_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_enc_bpsk.sv
// tb_enc_bpsk: self-checking bench for enc_bpsk. Two instances (CHIP_DIV=1
// and CHIP_DIV=3) are driven through a selector; captured frames are checked
// against hand-derived chip vectors and against a reference frame built from
// the sync word and the m-sequence recurrence, and each frame is despread
// by correlation to recover the byte.
module tb_enc_bpsk;

    localparam logic [30:0] SYNC = 31'b0011001100111100110000000011110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enc_bpsk_if if1 ();
    enc_bpsk_if if3 ();

    logic sig1, stb1, busy1, done1;
    logic sig3, stb3, busy3, done3;

    enc_bpsk #(.CHIP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .signal(sig1), .chip_stb(stb1), .busy(busy1), .frame_done(done1)
    );
    enc_bpsk #(.CHIP_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave),
        .signal(sig3), .chip_stb(stb3), .busy(busy3), .frame_done(done3)
    );

    logic       sel = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = '0;
    logic       o_sig, o_stb, o_busy, o_done, o_ready;

    always_comb begin
        if1.data_in    = tb_data;
        if3.data_in    = tb_data;
        if1.data_valid = tb_valid & ~sel;
        if3.data_valid = tb_valid & sel;
        o_sig   = sel ? sig3 : sig1;
        o_stb   = sel ? stb3 : stb1;
        o_busy  = sel ? busy3 : busy1;
        o_done  = sel ? done3 : done1;
        o_ready = sel ? if3.ready : if1.ready;
    end

    int  n_cmp = 0;
    int  n_bad = 0;
    logic seq [0:30];
    logic cap [0:278];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m-sequence from its linear recurrence: taps 0,2,3,4 of the 5-bit mask
    // give s[n+5] = s[n]^s[n+2]^s[n+3]^s[n+4], seeded with the seed bits.
    task automatic build_seq();
        logic [4:0] seed = 5'b10101;
        for (int n = 0; n < 5; n++) seq[n] = seed[n];
        for (int n = 0; n < 26; n++) seq[n+5] = seq[n] ^ seq[n+2] ^ seq[n+3] ^ seq[n+4];
    endtask

    function automatic logic model_chip(input logic [7:0] b, input int ci);
        int k;
        if (ci < 31) return SYNC[30 - ci];
        k = ci - 31;
        return seq[k % 31] ^ b[7 - k / 31];
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (o_ready !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        if (o_ready !== 1'b1) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
    endtask

    // Entered on the first clock after accept; returns on the first idle clock.
    task automatic frame_check(input logic [7:0] b);
        int d = sel ? 3 : 1;
        int n_cl = 279 * d;
        int terr = 0;
        int cerr = 0;
        int first = -1;
        logic [7:0] dec;
        for (int n = 1; n <= n_cl; n++) begin
            automatic int ci = (n - 1) / d;
            automatic logic first_clk = ((n - 1) % d == 0);
            if (first_clk) cap[ci] = o_sig;
            else if (o_sig !== cap[ci]) terr++;
            if (o_stb !== first_clk) terr++;
            if (o_done !== (n == n_cl)) terr++;
            if (o_busy !== 1'b1 || o_ready !== 1'b0) terr++;
            if (n != n_cl) tick();
        end
        for (int ci = 0; ci < 279; ci++) begin
            if (cap[ci] !== model_chip(b, ci)) begin
                cerr++;
                if (first < 0) first = ci;
            end
        end
        chk($sformatf("frame_timing_div%0d_%02h", d, b), terr, 0);
        chk($sformatf("frame_chips_div%0d_%02h_first%0d", d, b, first), cerr, 0);
        for (int i = 0; i < 8; i++) begin
            automatic int agree = 0;
            for (int k = 0; k < 31; k++) agree += int'(cap[31 + i*31 + k] ^ seq[k]);
            dec[7 - i] = (agree > 15);
        end
        chk($sformatf("loopback_decode_%02h", b), {24'd0, dec}, {24'd0, b});
        tick();
        chk("idle_after_frame", {28'd0, o_ready, o_busy, o_sig, o_done}, 32'b1000);
    endtask

    task automatic send_frame(input logic [7:0] b);
        wait_ready();
        tb_valid = 1'b1;
        tb_data  = b;
        tick();
        tb_valid = 1'b0;
        frame_check(b);
    endtask

    typedef struct {
        logic       sel;
        logic [7:0] data;
        int         chip;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cur_sel;
        int cur_b;
        logic [7:0] rb;

        vecs.push_back('{1'b0, 8'h00,   1, 1'b0});
        vecs.push_back('{1'b0, 8'h00,   2, 1'b0});
        vecs.push_back('{1'b0, 8'h00,   3, 1'b1});
        vecs.push_back('{1'b0, 8'h00,   5, 1'b0});
        vecs.push_back('{1'b0, 8'h00,  27, 1'b1});
        vecs.push_back('{1'b0, 8'h00,  31, 1'b0});
        vecs.push_back('{1'b0, 8'h00,  32, 1'b1});
        vecs.push_back('{1'b0, 8'h00,  33, 1'b0});
        vecs.push_back('{1'b0, 8'h00,  34, 1'b1});
        vecs.push_back('{1'b0, 8'h00,  35, 1'b0});
        vecs.push_back('{1'b0, 8'h00,  36, 1'b1});
        vecs.push_back('{1'b0, 8'h00,  63, 1'b1});
        vecs.push_back('{1'b0, 8'h00,  64, 1'b0});
        vecs.push_back('{1'b0, 8'hFF,   1, 1'b0});
        vecs.push_back('{1'b0, 8'hFF,   3, 1'b1});
        vecs.push_back('{1'b0, 8'hFF,  32, 1'b0});
        vecs.push_back('{1'b0, 8'hFF,  33, 1'b1});
        vecs.push_back('{1'b0, 8'hFF,  36, 1'b0});
        vecs.push_back('{1'b1, 8'hA5,   3, 1'b1});
        vecs.push_back('{1'b1, 8'hA5,  32, 1'b0});
        vecs.push_back('{1'b1, 8'hA5,  63, 1'b1});
        vecs.push_back('{1'b1, 8'hA5,  94, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 125, 1'b1});
        vecs.push_back('{1'b1, 8'hA5, 156, 1'b1});
        vecs.push_back('{1'b1, 8'hA5, 187, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 218, 1'b1});
        vecs.push_back('{1'b1, 8'hA5, 249, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 250, 1'b1});

        build_seq();

        rst = 1'b1;
        tick();
        tick();
        chk("reset_div1", {27'd0, if1.ready, sig1, stb1, busy1, done1}, 32'b10000);
        chk("reset_div3", {27'd0, if3.ready, sig3, stb3, busy3, done3}, 32'b10000);
        rst = 1'b0;
        tick();

        cur_sel = -1;
        cur_b   = -1;
        foreach (vecs[i]) begin
            if (int'(vecs[i].sel) != cur_sel || int'(vecs[i].data) != cur_b) begin
                sel = vecs[i].sel;
                send_frame(vecs[i].data);
                cur_sel = int'(vecs[i].sel);
                cur_b   = int'(vecs[i].data);
            end
            chk($sformatf("vec%0d_chip%0d", i, vecs[i].chip), {31'd0, cap[vecs[i].chip - 1]},
                {31'd0, vecs[i].exp});
        end

        // Back-to-back: valid held high; 8'h22 offered during the frame is
        // dropped and taken on the first idle clock.
        sel = 1'b0;
        wait_ready();
        tb_valid = 1'b1;
        tb_data  = 8'h11;
        tick();
        tb_data  = 8'h22;
        frame_check(8'h11);
        tick();
        tb_valid = 1'b0;
        frame_check(8'h22);

        // Reset at chip 100 aborts the frame; a fresh byte gets a full sync.
        sel = 1'b0;
        wait_ready();
        tb_valid = 1'b1;
        tb_data  = 8'h5A;
        tick();
        tb_valid = 1'b0;
        for (int n = 1; n < 100; n++) tick();
        chk("busy_at_chip100", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_midframe", {27'd0, o_ready, o_sig, o_stb, o_busy, o_done}, 32'b10000);
        tb_valid = 1'b1;
        tb_data  = 8'h3C;
        tick();
        tb_valid = 1'b0;
        frame_check(8'h3C);

        // Randomized frames on both dividers.
        for (int r = 0; r < 6; r++) begin
            sel = ($urandom_range(0, 1) == 1);
            rb  = 8'($urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            send_frame(rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
